// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART TX scheduling logic.
//   - tx_sched_state_t : scheduler FSM state encoding
//   - range constants   : legal bounds for data_bits / NUM_REQ, frame counter width
// No ports (package).
package uart_pkg;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;
  localparam int NUM_REQ_MIN   = 2;
  localparam int NUM_REQ_MAX   = 8;
  localparam int FRAME_CNT_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ISSUE      = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_WAIT_DONE  = 2'd3
  } tx_sched_state_t;

endpackage

// File: rtl/uart_rr_arbiter.sv
// uart_rr_arbiter: combinational round-robin pick.
// Returns the first asserted requester at or after rr_ptr, searching upward
// with wrap. The pointer register lives in the scheduler.
//   req_vld  in  NUM_REQ  request vector
//   rr_ptr   in  IDX_W    search start index
//   win_idx  out IDX_W    winning requester (0 when none)
//   any_req  out 1        at least one request asserted
module uart_rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_vld,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   win_idx,
  output logic               any_req
);

  logic [IDX_W-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest asserted
  // requester (smallest offset from rr_ptr) is the last one written.
  always_comb begin
    win_idx = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (req_vld[cand]) begin
        win_idx = cand;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one UART transmitter among NUM_REQ requesters.
// One launch pulse per frame, never while the transmitter is active; each
// frame is tracked until tx_active falls, and a launch the UART never picks
// up within START_TIMEOUT cycles is abandoned with an error pulse.
//   clk, rst           clock, synchronous active-high reset
//   req_vld/req_data   per-requester request and payload (slot i at i*data_bits)
//   req_rdy            one-hot acceptance pulse
//   uart_tx_data_in    latched payload to the UART
//   uart_tx_data_vld   one-cycle launch pulse to the UART
//   uart_tx_active     transmitter busy flag from the UART
//   grant_id           current / last granted requester
//   busy               high outside IDLE
//   start_timeout_err  one-cycle pulse on abandoned launch
//   frame_cnt          completed frames, wraps at 16 bits
//
// state       | meaning
// ------------+------------------------------------------------------
// IDLE        | waiting for a request while the UART is quiet
// ISSUE       | launch pulse and req_rdy out, pointer advances
// WAIT_START  | waiting for tx_active to rise, bounded by START_TIMEOUT
// WAIT_DONE   | frame on the line, waiting for tx_active to fall
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int data_bits     = 8,
  parameter int START_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_vld,
  input  logic [NUM_REQ*data_bits-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_rdy,
  output logic [data_bits-1:0]         uart_tx_data_in,
  output logic                         uart_tx_data_vld,
  input  logic                         uart_tx_active,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy,
  output logic                         start_timeout_err,
  output logic [FRAME_CNT_W-1:0]       frame_cnt
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMO_W = $clog2(START_TIMEOUT + 1);

  tx_sched_state_t        state_q, state_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [data_bits-1:0]   data_q, data_d;
  logic                   vld_q, vld_d;
  logic [NUM_REQ-1:0]     rdy_q, rdy_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;
  logic [FRAME_CNT_W-1:0] frame_q, frame_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;

  logic [IDX_W-1:0]       win_idx;
  logic                   any_req;
  logic [data_bits-1:0]   win_data;
  logic [NUM_REQ-1:0]     win_onehot;

  uart_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_vld (req_vld),
    .rr_ptr  (rr_ptr_q),
    .win_idx (win_idx),
    .any_req (any_req)
  );

  always_comb begin
    win_data   = '0;
    win_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_data = req_data[i*data_bits +: data_bits];
      end
      win_onehot[i] = (win_idx == IDX_W'(i));
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    data_d   = data_q;
    frame_d  = frame_q;
    tmo_d    = tmo_q;
    vld_d    = 1'b0;
    rdy_d    = '0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req && !uart_tx_active) begin
          state_d = ST_ISSUE;
          grant_d = win_idx;
          data_d  = win_data;
          // Registered here so the pulses are visible during ISSUE.
          vld_d   = 1'b1;
          rdy_d   = win_onehot;
        end
      end
      ST_ISSUE: begin
        rr_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
        // Down-counter: terminal count of 1 marks the START_TIMEOUT-th
        // cycle spent in WAIT_START.
        tmo_d    = TMO_W'(START_TIMEOUT);
        state_d  = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (uart_tx_active) begin
          state_d = ST_WAIT_DONE;
        end else if (tmo_q == TMO_W'(1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!uart_tx_active) begin
          frame_d = frame_q + FRAME_CNT_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      data_q   <= '0;
      vld_q    <= 1'b0;
      rdy_q    <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      frame_q  <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      data_q   <= data_d;
      vld_q    <= vld_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      frame_q  <= frame_d;
      tmo_q    <= tmo_d;
    end
  end

  assign req_rdy           = rdy_q;
  assign uart_tx_data_in   = data_q;
  assign uart_tx_data_vld  = vld_q;
  assign grant_id          = grant_q;
  assign busy              = busy_q;
  assign start_timeout_err = err_q;
  assign frame_cnt         = frame_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: self-checking bench for uart_tx_scheduler
// (NUM_REQ=4, data_bits=8, START_TIMEOUT=16) with a behavioural UART stub.
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_vld = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_rdy;
  logic [7:0]  uart_tx_data_in;
  logic        uart_tx_data_vld;
  logic        uart_tx_active;
  logic [1:0]  grant_id;
  logic        busy;
  logic        start_timeout_err;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .NUM_REQ       (4),
    .data_bits     (8),
    .START_TIMEOUT (16)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .req_vld           (req_vld),
    .req_data          (req_data),
    .req_rdy           (req_rdy),
    .uart_tx_data_in   (uart_tx_data_in),
    .uart_tx_data_vld  (uart_tx_data_vld),
    .uart_tx_active    (uart_tx_active),
    .grant_id          (grant_id),
    .busy              (busy),
    .start_timeout_err (start_timeout_err),
    .frame_cnt         (frame_cnt)
  );

  // UART stub: tx_active rises one cycle after the launch pulse and stays
  // high for stub_len cycles. When disabled, man_active drives the line.
  logic stub_en    = 1'b0;
  int   stub_len   = 3;
  logic man_active = 1'b0;
  logic model_active = 1'b0;
  int   st_wait = 0;
  int   st_len  = 0;

  always @(negedge clk) begin
    if (rst || !stub_en) begin
      model_active = 1'b0;
      st_wait      = 0;
      st_len       = 0;
    end else if (uart_tx_data_vld) begin
      st_wait = 1;
    end else if (st_wait > 0) begin
      st_wait      = 0;
      model_active = 1'b1;
      st_len       = stub_len;
    end else if (model_active) begin
      st_len--;
      if (st_len <= 0) model_active = 1'b0;
    end
  end

  assign uart_tx_active = stub_en ? model_active : man_active;

  // Monitor, sampled 1 time unit after each rising edge.
  int overlap_cnt = 0;
  int vld_cnt     = 0;
  int err_cnt     = 0;
  int rdy_cnt [4] = '{default: 0};

  always @(posedge clk) begin
    #1;
    if (uart_tx_data_vld && uart_tx_active) overlap_cnt++;
    if (uart_tx_data_vld) vld_cnt++;
    if (start_timeout_err) err_cnt++;
    for (int i = 0; i < 4; i++) if (req_rdy[i]) rdy_cnt[i]++;
  end

  typedef struct {
    logic [3:0]  vld;
    logic [31:0] data;
    logic [1:0]  grant;
    logic [7:0]  edata;
  } vec_t;

  typedef struct {
    logic [1:0] grant;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_vec      = 0;
  int   n_err      = 0;
  int   n_grants   = 0;
  int   exp_frames = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic expect_grant(input string nm, output int lat);
    exp_t e;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (req_rdy == 4'b0 && lat < 200);
    if (req_rdy == 4'b0) begin
      check({nm, " rdy wait expired"}, 32'd0, 32'd1);
      return;
    end
    if (sb.size() == 0) begin
      check({nm, " unexpected grant"}, {28'd0, req_rdy}, 32'd0);
      return;
    end
    e = sb.pop_front();
    n_grants++;
    check({nm, " grant_id"}, {30'd0, grant_id}, {30'd0, e.grant});
    check({nm, " tx_data_in"}, {24'd0, uart_tx_data_in}, {24'd0, e.data});
    check({nm, " req_rdy"}, {28'd0, req_rdy}, 32'd1 << e.grant);
    check({nm, " tx_data_vld"}, {31'd0, uart_tx_data_vld}, 32'd1);
    check({nm, " busy in issue"}, {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 200);
    if (busy) check({nm, " idle wait expired"}, 32'd1, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  vec_t vecs [8];
  int   lat;
  int   cyc;
  int   snap [4];
  logic [31:0] fair_data;

  initial begin
    vecs[0] = '{4'b0100, 32'h00A5_0000, 2'd2, 8'hA5};
    vecs[1] = '{4'b1111, 32'h4433_2211, 2'd3, 8'h44};
    vecs[2] = '{4'b0110, 32'h0066_5500, 2'd1, 8'h55};
    vecs[3] = '{4'b0011, 32'h0000_2010, 2'd0, 8'h10};
    vecs[4] = '{4'b1001, 32'h8000_0001, 2'd3, 8'h80};
    vecs[5] = '{4'b1000, 32'hFF00_0000, 2'd3, 8'hFF};
    vecs[6] = '{4'b0001, 32'h0000_005A, 2'd0, 8'h5A};
    vecs[7] = '{4'b0011, 32'h0000_3CC3, 2'd1, 8'h3C};

    // Reset values
    repeat (3) @(negedge clk);
    check("reset req_rdy", {28'd0, req_rdy}, 32'd0);
    check("reset tx_data_vld", {31'd0, uart_tx_data_vld}, 32'd0);
    check("reset tx_data_in", {24'd0, uart_tx_data_in}, 32'd0);
    check("reset grant_id", {30'd0, grant_id}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset err", {31'd0, start_timeout_err}, 32'd0);
    check("reset frame_cnt", {16'd0, frame_cnt}, 32'd0);
    rst = 1'b0;

    // Table vectors, one frame each, round-robin pointer carried across
    stub_en  = 1'b1;
    stub_len = 3;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      req_vld  = vecs[i].vld;
      req_data = vecs[i].data;
      sb.push_back('{grant: vecs[i].grant, data: vecs[i].edata});
      expect_grant($sformatf("vec%0d", i), lat);
      check($sformatf("vec%0d latency", i), lat, 32'd1);
      req_vld = '0;
      wait_idle($sformatf("vec%0d", i));
      exp_frames++;
      check($sformatf("vec%0d frame_cnt", i), {16'd0, frame_cnt}, exp_frames);
    end

    // Busy blocking: request held while tx_active is high
    stub_en    = 1'b0;
    man_active = 1'b1;
    req_vld    = 4'b0001;
    req_data   = 32'h0000_003E;
    sb.push_back('{grant: 2'd0, data: 8'h3E});
    cyc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (uart_tx_data_vld || req_rdy != 4'b0 || busy) cyc++;
    end
    check("blocked while active", cyc, 32'd0);
    man_active = 1'b0;
    expect_grant("blocking", lat);
    check("blocking latency after fall", lat, 32'd1);
    req_vld = '0;
    @(negedge clk);
    man_active = 1'b1;
    repeat (3) @(negedge clk);
    man_active = 1'b0;
    wait_idle("blocking");
    exp_frames++;
    check("blocking frame_cnt", {16'd0, frame_cnt}, exp_frames);

    // Start timeout: the UART never responds
    req_vld  = 4'b0010;
    req_data = 32'h0000_9900;
    sb.push_back('{grant: 2'd1, data: 8'h99});
    expect_grant("timeout", lat);
    req_vld = '0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!start_timeout_err && cyc < 40);
    check("timeout err delay", cyc, 32'd17);
    check("timeout busy", {31'd0, busy}, 32'd0);
    check("timeout frame_cnt", {16'd0, frame_cnt}, exp_frames);
    @(negedge clk);
    check("timeout err one cycle", {31'd0, start_timeout_err}, 32'd0);

    // Reset in WAIT_DONE
    stub_en  = 1'b1;
    stub_len = 20;
    req_vld  = 4'b0100;
    req_data = 32'h0011_0000;
    sb.push_back('{grant: 2'd2, data: 8'h11});
    expect_grant("midreset", lat);
    req_vld = '0;
    repeat (3) @(negedge clk);
    check("midreset busy before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midreset busy", {31'd0, busy}, 32'd0);
    check("midreset frame_cnt", {16'd0, frame_cnt}, 32'd0);
    check("midreset grant_id", {30'd0, grant_id}, 32'd0);
    check("midreset req_rdy", {28'd0, req_rdy}, 32'd0);
    check("midreset tx_data_vld", {31'd0, uart_tx_data_vld}, 32'd0);
    check("midreset err", {31'd0, start_timeout_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_frames = 0;
    stub_len = 2;
    // rr_ptr back at 0: requester 0 wins over 3
    req_vld  = 4'b1001;
    req_data = 32'h7700_0066;
    sb.push_back('{grant: 2'd0, data: 8'h66});
    expect_grant("postreset ptr", lat);
    req_vld = '0;
    wait_idle("postreset ptr");
    exp_frames++;
    req_vld  = 4'b1000;
    sb.push_back('{grant: 2'd3, data: 8'h77});
    expect_grant("postreset req3", lat);
    check("postreset req3 latency", lat, 32'd1);
    req_vld = '0;
    wait_idle("postreset req3");
    exp_frames++;
    check("postreset frame_cnt", {16'd0, frame_cnt}, exp_frames);

    // Fairness: all four held valid for 8 frames, pointer starts at 0
    for (int i = 0; i < 4; i++) snap[i] = rdy_cnt[i];
    fair_data = 32'hD3C2_B1A0;
    req_data  = fair_data;
    req_vld   = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      sb.push_back('{grant: 2'(k % 4), data: 8'(fair_data >> (8 * (k % 4)))});
    end
    for (int k = 0; k < 8; k++) begin
      expect_grant($sformatf("fair%0d", k), lat);
      if (k == 7) req_vld = '0;
    end
    wait_idle("fairness");
    exp_frames += 8;
    check("fairness frame_cnt", {16'd0, frame_cnt}, exp_frames);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fairness rdy count req%0d", i), rdy_cnt[i] - snap[i], 32'd2);
    end

    // Whole-run properties
    repeat (2) @(negedge clk);
    check("vld and active overlap", overlap_cnt, 32'd0);
    check("launch pulses vs grants", vld_cnt, n_grants);
    check("error pulse count", err_cnt, 32'd1);
    check("scoreboard drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
